// File: rtl/regfile_pkg.sv
// Shared constants for the decoded register file: default geometry and the
// index of the hardwired zero register.
package regfile_pkg;
   localparam int RF_WIDTH     = 32;
   localparam int RF_ADDR_BITS = 5;
   localparam int RF_NUM_RD    = 2;
   localparam int RF_ZERO_IDX  = 0;
endpackage

// File: rtl/regfile_decoded_if.sv
// Register-file bus: one write port plus NUM_RD registered read ports.
// Handshake: no back-pressure; RE[p] sampled at an edge yields RVALID[p]=1 for the following cycle.
interface regfile_decoded_if
   import regfile_pkg::*;
#(
   parameter int WIDTH     = RF_WIDTH,
   parameter int ADDR_BITS = RF_ADDR_BITS,
   parameter int NUM_RD    = RF_NUM_RD
);
   logic                        WE;
   logic [ADDR_BITS-1:0]        WADDR;
   logic [WIDTH-1:0]            WDATA;
   logic [NUM_RD-1:0]           RE;
   logic [NUM_RD*ADDR_BITS-1:0] RADDR;
   logic [NUM_RD*WIDTH-1:0]     RDATA;
   logic [NUM_RD-1:0]           RVALID;

   modport master (
      output WE, WADDR, WDATA, RE, RADDR,
      input  RDATA, RVALID
   );

   modport slave (
      input  WE, WADDR, WDATA, RE, RADDR,
      output RDATA, RVALID
   );
endinterface

// File: rtl/regfile_decoded_decoder.sv
// Generic N-to-2**N one-hot decoder with a global enable.
module onehot_decoder #(
   parameter int N = 5
) (
   input  logic [N-1:0]    SELECT,
   input  logic            EN,
   output logic [2**N-1:0] OUT
);
   always_comb begin
      OUT = '0;
      for (int i = 0; i < 2**N; i++) begin
         OUT[i] = EN && (SELECT == N'(i));
      end
   end
endmodule

// File: rtl/regfile_decoded.sv
// Register file: one decoded write port, NUM_RD registered read ports, register 0 reads as zero.
// Optional same-edge write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_decoded
   import regfile_pkg::*;
#(
   parameter int WIDTH     = RF_WIDTH,
   parameter int ADDR_BITS = RF_ADDR_BITS,
   parameter int NUM_RD    = RF_NUM_RD
) (
   input logic               CLK,
   input logic               RST_N,
   regfile_decoded_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_BITS;

   logic [DEPTH-1:0] wsel;
   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [NUM_RD*WIDTH-1:0] rdata_all;
   logic [NUM_RD-1:0]       rvalid_all;

   onehot_decoder #(.N(ADDR_BITS)) u_wdec (
      .SELECT (bus.WADDR),
      .EN     (bus.WE),
      .OUT    (wsel)
   );

   // Slot 0 is never loaded, so it stays at its reset value of zero.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
         if (wsel[i] && (i != RF_ZERO_IDX)) begin
            regs_d[i] = bus.WDATA;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_BITS-1:0] raddr;
      logic [WIDTH-1:0]     rd_word;
      logic [WIDTH-1:0]     rdata_d, rdata_q;
      logic                 rvalid_d, rvalid_q;

      assign raddr = bus.RADDR[p*ADDR_BITS +: ADDR_BITS];

      always_comb begin
         rd_word = regs_q[raddr];
`ifdef REGFILE_BYPASS_EN
         if (bus.WE && (bus.WADDR == raddr)) rd_word = bus.WDATA;
`endif
         if (raddr == ADDR_BITS'(RF_ZERO_IDX)) rd_word = '0;
         rdata_d  = bus.RE[p] ? rd_word : rdata_q;
         rvalid_d = bus.RE[p];
      end

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
         end
      end

      assign rdata_all[p*WIDTH +: WIDTH] = rdata_q;
      assign rvalid_all[p]               = rvalid_q;
   end

   assign bus.RDATA  = rdata_all;
   assign bus.RVALID = rvalid_all;
endmodule

// File: tb/tb_regfile_decoded.sv
// Randomised and directed bench for regfile_decoded with a queue-based scoreboard,
// plus a small 8-bit/3-port instance and a standalone decoder check.
module tb_regfile_decoded;
   import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic CLK;
   logic RST_N;

   regfile_decoded_if #(.WIDTH(32), .ADDR_BITS(5), .NUM_RD(2)) bus ();
   regfile_decoded_if #(.WIDTH(8),  .ADDR_BITS(3), .NUM_RD(3)) bus8 ();

   regfile_decoded #(.WIDTH(32), .ADDR_BITS(5), .NUM_RD(2)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   regfile_decoded #(.WIDTH(8), .ADDR_BITS(3), .NUM_RD(3)) dut8 (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus8)
   );

   logic [2:0] dsel;
   logic       den;
   logic [7:0] dout;

   onehot_decoder #(.N(3)) dec3 (
      .SELECT (dsel),
      .EN     (den),
      .OUT    (dout)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // scoreboard state: reference memory, last returned word per port, expected queues
   logic [31:0] mem [32];
   logic [31:0] last [2];
   logic [32:0] exp_q0 [$];
   logic [32:0] exp_q1 [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] ra, input bit we,
                                              input logic [4:0] wa, input logic [31:0] wd);
      if (ra == 5'd0) return 32'd0;
      if (BYP && we && (wa == ra)) return wd;
      return mem[ra];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      last[0] = 32'd0;
      last[1] = 32'd0;
      exp_q0.delete();
      exp_q1.delete();
   endtask

   // driver: one call = one clock cycle of stimulus
   task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
      @(negedge CLK);
      bus.WE    = we;
      bus.WADDR = wa;
      bus.WDATA = wd;
      bus.RE    = re;
      bus.RADDR = {ra1, ra0};
      if (re[0]) last[0] = model_read(ra0, we, wa, wd);
      if (re[1]) last[1] = model_read(ra1, we, wa, wd);
      exp_q0.push_back({re[0], last[0]});
      exp_q1.push_back({re[1], last[1]});
      if (we && (wa != 5'd0)) mem[wa] = wd;
   endtask

   task automatic idle_inputs();
      bus.WE = 1'b0;  bus.WADDR = '0; bus.WDATA = '0; bus.RE = '0; bus.RADDR = '0;
      bus8.WE = 1'b0; bus8.WADDR = '0; bus8.WDATA = '0; bus8.RE = '0; bus8.RADDR = '0;
   endtask

   // Reset between edges while reads are in flight; outputs must clear at once.
   task automatic reset_mid();
      @(posedge CLK);
      #4;
      RST_N = 1'b0;
      idle_inputs();
      #1;
      check("rst_mid_rdata",  {32'd0, bus.RDATA},  64'd0);
      check("rst_mid_rvalid", {62'd0, bus.RVALID}, 64'd0);
      model_clear();
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   // monitor: pop and compare one expectation per port after every edge
   always @(posedge CLK) begin
      logic [32:0] e;
      #2;
      if (exp_q0.size() > 0) begin
         e = exp_q0.pop_front();
         check("port0", {31'd0, bus.RVALID[0], bus.RDATA[31:0]}, {31'd0, e});
      end
      if (exp_q1.size() > 0) begin
         e = exp_q1.pop_front();
         check("port1", {31'd0, bus.RVALID[1], bus.RDATA[63:32]}, {31'd0, e});
      end
   end

   initial begin
      logic [4:0]  wa, ra0, ra1;
      logic [31:0] wd;
      int          budget;

      RST_N = 1'b1;
      idle_inputs();
      dsel = '0;
      den  = 1'b0;
      model_clear();
      #2;
      RST_N = 1'b0;
      #1;
      check("rst_rdata",  {32'd0, bus.RDATA},  64'd0);
      check("rst_rvalid", {62'd0, bus.RVALID}, 64'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;

      // mid-operation reset: reg 5 must be empty afterwards
      drive(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 32'd0,        2'b11, 5'd5, 5'd5);
      reset_mid();
      drive(1'b0, 5'd0, 32'd0,        2'b01, 5'd5, 5'd0);

      // basic write then read
      drive(1'b1, 5'd3, 32'h12345678, 2'b00, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 32'd0,        2'b01, 5'd3, 5'd0);

      // zero register on both ports
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 2'b00, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 32'd0,        2'b11, 5'd0, 5'd0);

      // same-edge write/read of reg 7, then a follow-up read
      drive(1'b1, 5'd7, 32'h11, 2'b00, 5'd0, 5'd0);
      drive(1'b1, 5'd7, 32'h22, 2'b11, 5'd7, 5'd7);
      drive(1'b0, 5'd0, 32'd0,  2'b11, 5'd7, 5'd7);

      // sweep: write i to every address, then read crosswise every cycle
      for (int i = 1; i < 32; i++) drive(1'b1, 5'(i), 32'(i), 2'b00, 5'd0, 5'd0);
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 32'd0, (i == 10) ? 2'b01 : 2'b11, 5'(i), 5'(31 - i));
      end

      // randomised traffic, often aiming a read at the write address
      for (int n = 0; n < 400; n++) begin
         wa  = 5'($urandom_range(0, 31));
         wd  = $urandom;
         ra0 = ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31));
         ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 1)), wa, wd, 2'($urandom_range(0, 3)), ra0, ra1);
      end
      drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);

      budget = 20;
      while ((exp_q0.size() > 0 || exp_q1.size() > 0) && budget > 0) begin
         @(posedge CLK);
         budget--;
      end
      #3;
      check("drain_timeout", {32'd0, 16'(exp_q0.size()), 16'(exp_q1.size())}, 64'd0);

      // narrow instance: three ports read the same register
      @(negedge CLK);
      bus8.WE = 1'b1; bus8.WADDR = 3'd6; bus8.WDATA = 8'hA5;
      @(negedge CLK);
      bus8.WE = 1'b0; bus8.RE = 3'b111; bus8.RADDR = {3'd6, 3'd6, 3'd6};
      @(posedge CLK);
      #2;
      for (int p = 0; p < 3; p++) begin
         check("p8_rdata", {56'd0, bus8.RDATA[p*8 +: 8]}, 64'hA5);
      end
      check("p8_rvalid", {61'd0, bus8.RVALID}, 64'd7);
      @(negedge CLK);
      bus8.RE = 3'b000;

      // standalone decoder one-hot
      dsel = 3'd6; den = 1'b1;
      #1 check("dec_sel6", {56'd0, dout}, 64'h40);
      den = 1'b0;
      #1 check("dec_en0",  {56'd0, dout}, 64'h00);
      dsel = 3'd0; den = 1'b1;
      #1 check("dec_sel0", {56'd0, dout}, 64'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
